// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// mem_access_ctrl : MEM-stage load/store sequencer with byte enables,
//                   load extension and misalignment fault detection.
// Revision 1.0
// ============================================================================
module mem_access_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_stall,
  output logic        o_load_valid,
  output logic [31:0] o_load_data,
  output logic [4:0]  o_rd_num,
  output logic        o_fault
);

  localparam logic [6:0] C_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] C_OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_mem_op;
  logic        w_legal;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  logic        r_fault;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_wdata;
  logic [4:0]  r_rd_num;
  logic [2:0]  r_func_3;
  logic [1:0]  r_offset;
  logic [31:0] r_load_data;

  assign w_is_load  = (i_opcode == C_OP_LOAD);
  assign w_is_store = (i_opcode == C_OP_STORE);
  assign w_mem_op   = i_valid & (w_is_load | w_is_store);

  // Size encoding lives in func_3[1:0]; func_3[2] selects unsigned loads.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = i_rs_2;
    case (i_func_3[1:0])
      2'b00: begin
        w_legal = w_is_load | (w_is_store & ~i_func_3[2]);
        w_be    = 4'b0001 << i_alu_out[1:0];
        w_wdata = {4{i_rs_2[7:0]}};
      end
      2'b01: begin
        w_legal = (w_is_load | (w_is_store & ~i_func_3[2])) & ~i_alu_out[0];
        w_be    = i_alu_out[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_rs_2[15:0]}};
      end
      2'b10: begin
        w_legal = ~i_func_3[2] & (i_alu_out[1:0] == 2'b00);
        w_be    = 4'b1111;
        w_wdata = i_rs_2;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
        w_wdata = i_rs_2;
      end
    endcase
  end

  assign w_shifted = i_mem_rdata >> {r_offset, 3'b000};

  always_comb begin
    case (r_func_3)
      3'b000:  w_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ext = {24'd0, w_shifted[7:0]};
      3'b101:  w_ext = {16'd0, w_shifted[15:0]};
      default: w_ext = w_shifted;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_stall      = 1'b0;
    o_mem_req    = 1'b0;
    o_load_valid = 1'b0;
    o_fault      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          o_stall = 1'b1;
          w_next  = w_legal ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        if (i_mem_ack) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_load_valid = ~r_fault & ~r_mem_we;
        o_fault      = r_fault;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Request fields are only loaded in IDLE, so they hold steady through REQ.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fault     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
      r_rd_num    <= 5'd0;
      r_func_3    <= 3'd0;
      r_offset    <= 2'd0;
      r_load_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mem_op) begin
            r_fault <= ~w_legal;
            if (w_legal) begin
              r_mem_we    <= w_is_store;
              r_mem_addr  <= {i_alu_out[31:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_rd_num    <= i_rd_num;
              r_func_3    <= i_func_3;
              r_offset    <= i_alu_out[1:0];
            end
          end
        end
        S_REQ: begin
          if (i_mem_ack && !r_mem_we) begin
            r_load_data <= w_ext;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_load_data = r_load_data;
  assign o_rd_num    = r_rd_num;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_access_ctrl : randomized bench for mem_access_ctrl against a
//                      transaction-level reference model.
// Revision 1.0
// ============================================================================
module tb_mem_access_ctrl;

  localparam logic [6:0] C_LOAD  = 7'b0000011;
  localparam logic [6:0] C_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [6:0]  i_opcode = 7'd0;
  logic [2:0]  i_func_3 = 3'd0;
  logic [31:0] i_alu_out = 32'd0;
  logic [31:0] i_rs_2 = 32'd0;
  logic [4:0]  i_rd_num = 5'd0;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'd0;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        o_stall;
  logic        o_load_valid;
  logic [31:0] o_load_data;
  logic [4:0]  o_rd_num;
  logic        o_fault;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl u_dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_opcode     (i_opcode),
    .i_func_3     (i_func_3),
    .i_alu_out    (i_alu_out),
    .i_rs_2       (i_rs_2),
    .i_rd_num     (i_rd_num),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_be     (o_mem_be),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_stall      (o_stall),
    .o_load_valid (o_load_valid),
    .o_load_data  (o_load_data),
    .o_rd_num     (o_rd_num),
    .o_fault      (o_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    i_valid     = 1'b0;
    i_opcode    = 7'($urandom);
    i_func_3    = 3'($urandom);
    i_alu_out   = $urandom;
    i_rs_2      = $urandom;
    i_rd_num    = 5'($urandom);
    i_mem_ack   = 1'b0;
    i_mem_rdata = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"},   32'(o_mem_req),    32'd0);
    check({tag, "_stall"}, 32'(o_stall),      32'd0);
    check({tag, "_we"},    32'(o_mem_we),     32'd0);
    check({tag, "_addr"},  o_mem_addr,        32'd0);
    check({tag, "_be"},    32'(o_mem_be),     32'd0);
    check({tag, "_wdata"}, o_mem_wdata,       32'd0);
    check({tag, "_lv"},    32'(o_load_valid), 32'd0);
    check({tag, "_ldata"}, o_load_data,       32'd0);
    check({tag, "_rd"},    32'(o_rd_num),     32'd0);
    check({tag, "_fault"}, 32'(o_fault),      32'd0);
  endtask

  // One instruction presented in cycle 0; ack arrives in cycle lat (>= 1).
  task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input int lat,
                       input logic [31:0] rdata, input logic ack0);
    logic        ld, st, legal;
    int          nbytes, off;
    logic [31:0] e_be, e_wd, e_ld, mask;
    ld     = (op == C_LOAD);
    st     = (op == C_STORE);
    off    = int'(addr[1:0]);
    nbytes = 1 << f3[1:0];
    legal  = (ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) || (st && f3 <= 3'd2);
    if (legal && (addr % nbytes) != 0) legal = 1'b0;
    e_be = ((32'd1 << nbytes) - 32'd1) << off;
    case (nbytes)
      1:       e_wd = rs2[7:0] * 32'h01010101;
      2:       e_wd = rs2[15:0] * 32'h00010001;
      default: e_wd = rs2;
    endcase
    e_ld = rdata >> (8 * off);
    if (nbytes < 4) begin
      mask = (32'd1 << (8 * nbytes)) - 32'd1;
      e_ld = e_ld & mask;
      if (!f3[2] && e_ld[8 * nbytes - 1]) e_ld = e_ld | ~mask;
    end

    @(posedge clk); #1;
    i_valid = 1'b1; i_opcode = op; i_func_3 = f3; i_alu_out = addr;
    i_rs_2 = rs2; i_rd_num = rd; i_mem_ack = ack0; i_mem_rdata = $urandom;
    @(negedge clk);
    check("stall_c0", 32'(o_stall), 32'(ld || st));
    check("req_c0", 32'(o_mem_req), 32'd0);

    if (!(ld || st)) begin
      @(posedge clk); #1; drive_idle();
      @(negedge clk);
      check("bypass_req", 32'(o_mem_req), 32'd0);
      check("bypass_pulse", 32'(o_load_valid | o_fault), 32'd0);
      return;
    end

    if (!legal) begin
      @(posedge clk); #1; drive_idle();
      @(negedge clk);
      check("fault_pulse", 32'(o_fault), 32'd1);
      check("fault_stall", 32'(o_stall), 32'd0);
      check("fault_req", 32'(o_mem_req), 32'd0);
      check("fault_lv", 32'(o_load_valid), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("fault_once", 32'(o_fault), 32'd0);
      check("fault_noreq", 32'(o_mem_req), 32'd0);
      return;
    end

    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      i_valid     = 1'($urandom);
      i_opcode    = ($urandom_range(0, 1) != 0) ? C_LOAD : C_STORE;
      i_alu_out   = $urandom;
      i_rs_2      = $urandom;
      i_mem_ack   = (c == lat);
      i_mem_rdata = (c == lat) ? rdata : $urandom;
      @(negedge clk);
      check("req_hi", 32'(o_mem_req), 32'd1);
      check("req_stall", 32'(o_stall), 32'd1);
      check("req_we", 32'(o_mem_we), 32'(st));
      check("req_addr", o_mem_addr, {addr[31:2], 2'b00});
      check("req_be", 32'(o_mem_be), e_be);
      if (st) check("req_wdata", o_mem_wdata, e_wd);
      check("req_nopulse", 32'(o_load_valid | o_fault), 32'd0);
    end

    // DONE must ignore a live-looking memory op on its inputs.
    @(posedge clk); #1;
    i_mem_ack = 1'b0; i_valid = 1'b1; i_opcode = C_LOAD; i_func_3 = 3'd2; i_alu_out = 32'd0;
    @(negedge clk);
    check("done_stall", 32'(o_stall), 32'd0);
    check("done_req", 32'(o_mem_req), 32'd0);
    check("done_lv", 32'(o_load_valid), 32'(ld));
    check("done_fault", 32'(o_fault), 32'd0);
    if (ld) begin
      check("done_ldata", o_load_data, e_ld);
      check("done_rd", 32'(o_rd_num), 32'(rd));
    end
    @(posedge clk); #1; drive_idle();
  endtask

  task automatic reset_mid_access();
    @(posedge clk); #1;
    i_valid = 1'b1; i_opcode = C_LOAD; i_func_3 = 3'd2; i_alu_out = 32'h0000_0200;
    i_rd_num = 5'd9; i_mem_ack = 1'b0;
    @(negedge clk);
    check("rst_c0_stall", 32'(o_stall), 32'd1);
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    check("rst_req_hi", 32'(o_mem_req), 32'd1);
    @(posedge clk); #1;
    i_rst = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(negedge clk);
    check("rst_late_ack_lv", 32'(o_load_valid), 32'd0);
    check("rst_late_ack_req", 32'(o_mem_req), 32'd0);
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    check("rst_after_pulse", 32'(o_load_valid | o_fault), 32'd0);
  endtask

  initial begin
    drive_idle();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; i_rst = 1'b0;
    @(negedge clk);
    check("post_reset_stall", 32'(o_stall), 32'd0);

    do_op(C_STORE, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 1, 32'd0, 1'b0);
    do_op(C_LOAD,  3'd0, 32'h0000_0103, 32'd0, 5'd5, 1, 32'h80FF_0000, 1'b0);
    do_op(C_LOAD,  3'd5, 32'h0000_0102, 32'd0, 5'd7, 2, 32'h8001_1234, 1'b1);
    do_op(C_STORE, 3'd1, 32'h0000_0101, 32'h1111_2222, 5'd0, 1, 32'd0, 1'b0);
    do_op(C_STORE, 3'd0, 32'h0000_0102, 32'h0000_00AB, 5'd0, 6, 32'd0, 1'b0);
    do_op(C_LOAD,  3'd1, 32'h0000_0206, 32'd0, 5'd0, 3, 32'hA5C3_0F0F, 1'b0);
    do_op(C_LOAD,  3'd3, 32'h0000_0200, 32'd0, 5'd1, 1, 32'd0, 1'b0);
    do_op(C_LOAD,  3'd2, 32'h0000_0202, 32'd0, 5'd1, 1, 32'd0, 1'b0);
    do_op(7'b0110011, 3'd0, 32'h0000_0200, 32'd0, 5'd1, 1, 32'd0, 1'b0);
    reset_mid_access();

    for (int t = 0; t < 300; t++) begin
      logic [6:0] op;
      int         r;
      r = $urandom_range(0, 9);
      if (r < 4)      op = C_LOAD;
      else if (r < 8) op = C_STORE;
      else            op = 7'($urandom);
      do_op(op, 3'($urandom), $urandom, $urandom, 5'($urandom),
            $urandom_range(1, 4), $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
